// File: rtl/shift_reg_burst.sv
// ============================================================================
// shift_reg_burst : WIDTH-bit universal shift register with a self-timed
//                   right-shift burst engine (busy/done status).
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_burst #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_i,
    input  logic             start_i,
    input  logic [CW-1:0]    cnt_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [CW-1:0] C_WIDTH = CW'(WIDTH);

    localparam logic [2:0] C_HOLD   = 3'b000;
    localparam logic [2:0] C_LOAD   = 3'b001;
    localparam logic [2:0] C_SHL    = 3'b010;
    localparam logic [2:0] C_SHR    = 3'b011;
    localparam logic [2:0] C_ROTL   = 3'b100;
    localparam logic [2:0] C_ROTR   = 3'b101;
    localparam logic [2:0] C_CLEAR  = 3'b110;
    localparam logic [2:0] C_INVERT = 3'b111;

    state_t           state_q, state_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_sat;

    // Requests longer than the register saturate to a full-width burst.
    assign cnt_sat = (cnt_i > C_WIDTH) ? C_WIDTH : cnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            reg_q   <= RST_VAL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            reg_q   <= reg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        reg_d   = reg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rem_d = cnt_sat;
                    if (cnt_sat != '0) begin
                        state_d = S_SHIFT;
                        busy_d  = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end else if (en_i) begin
                    unique case (mode_i)
                        C_HOLD:   reg_d = reg_q;
                        C_LOAD:   reg_d = d_i;
                        C_SHL:    reg_d = {reg_q[WIDTH-2:0], sin_i};
                        C_SHR:    reg_d = {sin_i, reg_q[WIDTH-1:1]};
                        C_ROTL:   reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
                        C_ROTR:   reg_d = {reg_q[0], reg_q[WIDTH-1:1]};
                        C_CLEAR:  reg_d = '0;
                        C_INVERT: reg_d = ~reg_q;
                        default:  reg_d = reg_q;
                    endcase
                end
            end
            S_SHIFT: begin
                reg_d = {sin_i, reg_q[WIDTH-1:1]};
                rem_d = rem_q - 1'b1;
                if (rem_q == CW'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign q_o    = reg_q;
    assign sout_o = reg_q[0];
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_burst.sv
// ============================================================================
// tb_shift_reg_burst : directed scoreboard bench for shift_reg_burst.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_burst;

    localparam int         WIDTH = 8;
    localparam int         CW    = $clog2(WIDTH + 1);
    localparam logic [7:0] RSTV  = 8'hA5;

    typedef struct packed {
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [2:0]    mode;
    logic [7:0]    d;
    logic          sin;
    logic          start;
    logic [CW-1:0] cnt;
    logic [7:0]    q;
    logic          sout;
    logic          busy;
    logic          done;

    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t sb[$];

    shift_reg_burst #(
        .WIDTH   (WIDTH),
        .RST_VAL (RSTV)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .mode_i  (mode),
        .d_i     (d),
        .sin_i   (sin),
        .start_i (start),
        .cnt_i   (cnt),
        .q_o     (q),
        .sout_o  (sout),
        .busy_o  (busy),
        .done_o  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge state,
    // then pop and compare once the edge has settled.
    task automatic cycle(input string tag, input logic i_en, input logic [2:0] i_mode,
                         input logic [7:0] i_d, input logic i_sin, input logic i_start,
                         input logic [CW-1:0] i_cnt, input logic [7:0] e_q,
                         input logic e_busy, input logic e_done);
        exp_t e;
        en = i_en; mode = i_mode; d = i_d; sin = i_sin; start = i_start; cnt = i_cnt;
        sb.push_back('{q: e_q, busy: e_busy, done: e_done});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".q"},    32'(q),    32'(e.q));
        chk({tag, ".sout"}, 32'(sout), 32'(e.q[0]));
        chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
        chk({tag, ".done"}, 32'(done), 32'(e.done));
    endtask

    initial begin
        logic [7:0] m;
        rst_n = 1'b1; en = 0; mode = 0; d = 0; sin = 0; start = 0; cnt = '0;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async.q",    32'(q),    32'(RSTV));
        chk("rst_async.busy", 32'(busy), 32'h0);
        chk("rst_async.done", 32'(done), 32'h0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;

        // Mode operations
        cycle("load96",  1, 3'b001, 8'h96, 0, 0, 0, 8'h96, 0, 0);
        cycle("shl",     1, 3'b010, 8'h00, 1, 0, 0, 8'h2D, 0, 0);
        cycle("rotr",    1, 3'b101, 8'h00, 0, 0, 0, 8'h96, 0, 0);
        cycle("invert",  1, 3'b111, 8'h00, 0, 0, 0, 8'h69, 0, 0);
        cycle("rotl",    1, 3'b100, 8'h00, 0, 0, 0, 8'hD2, 0, 0);
        cycle("shr",     1, 3'b011, 8'h00, 1, 0, 0, 8'hE9, 0, 0);
        cycle("clear",   1, 3'b110, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        cycle("en0hold", 0, 3'b001, 8'hFF, 0, 0, 0, 8'h00, 0, 0);
        cycle("loadC3",  1, 3'b001, 8'hC3, 0, 0, 0, 8'hC3, 0, 0);
        cycle("mhold",   1, 3'b000, 8'h5A, 1, 0, 0, 8'hC3, 0, 0);

        // Burst of 3, sin=0: sout 1,1,0 then q=18
        cycle("b3.start", 0, 3'b000, 8'h00, 0, 1, 3, 8'hC3, 1, 0);
        cycle("b3.s1",    0, 3'b000, 8'h00, 0, 0, 0, 8'h61, 1, 0);
        cycle("b3.s2",    0, 3'b000, 8'h00, 0, 0, 0, 8'h30, 1, 0);
        cycle("b3.s3",    0, 3'b000, 8'h00, 0, 0, 0, 8'h18, 0, 1);
        cycle("b3.after", 0, 3'b000, 8'h00, 0, 0, 0, 8'h18, 0, 0);

        // Zero-length burst
        cycle("b0.start", 1, 3'b110, 8'h00, 0, 1, 0, 8'h18, 0, 1);
        cycle("b0.after", 0, 3'b000, 8'h00, 0, 0, 0, 8'h18, 0, 0);

        // cnt=15 saturates to 8 shifts of sin=1
        m = 8'h18;
        cycle("b15.start", 0, 3'b000, 8'h00, 1, 1, 15, m, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            m = {1'b1, m[7:1]};
            cycle($sformatf("b15.s%0d", i), 0, 3'b000, 8'h00, 1, 0, 0, m, (i < 8), (i == 8));
        end
        cycle("b15.after", 0, 3'b000, 8'h00, 0, 0, 0, 8'hFF, 0, 0);

        // start with en/load in the same cycle: load discarded
        cycle("col.start",  1, 3'b001, 8'h00, 0, 1, 2, 8'hFF, 1, 0);
        cycle("col.midst",  1, 3'b001, 8'h00, 0, 1, 5, 8'h7F, 1, 0);
        cycle("col.done",   0, 3'b000, 8'h00, 0, 0, 0, 8'h3F, 0, 1);
        // Back-to-back start while done is high
        cycle("b2b.start",  0, 3'b000, 8'h00, 1, 1, 1, 8'h3F, 1, 0);
        cycle("b2b.done",   0, 3'b000, 8'h00, 1, 0, 0, 8'h9F, 0, 1);
        cycle("b2b.after",  0, 3'b000, 8'h00, 1, 0, 0, 8'h9F, 0, 0);

        // Abort: reset two cycles into a 5-shift burst
        cycle("ab.start", 0, 3'b000, 8'h00, 0, 1, 5, 8'h9F, 1, 0);
        cycle("ab.s1",    0, 3'b000, 8'h00, 0, 0, 0, 8'h4F, 1, 0);
        cycle("ab.s2",    0, 3'b000, 8'h00, 0, 0, 0, 8'h27, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ab.rst.q",    32'(q),    32'(RSTV));
        chk("ab.rst.busy", 32'(busy), 32'h0);
        chk("ab.rst.done", 32'(done), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle($sformatf("ab.post%0d", i), 0, 3'b000, 8'h00, 0, 0, 0, RSTV, 0, 0);
        end

        chk("sb.empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_reg_burst.md
# shift_reg_burst

Parameterised universal shift register: the multi-mode, WIDTH-bit successor to the team's single-bit D flip-flop. Supports hold, parallel load, logical shifts, rotates, clear and invert under a mode select. A burst engine shifts the register right a programmed number of times on its own, with busy/done status. Used as the general storage and serialisation element in behavioural test designs and small datapaths.

## Interface
- WIDTH, 8: register width in bits, minimum 2.
- RST_VAL, {WIDTH{1'b0}}: value loaded into q on reset.
- CW, $clog2(WIDTH+1): width of the burst count input (derived, do not override).

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  enables mode operation when idle.
- mode  input  3  operation select; see Operation.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input bit for shifts and bursts.
- start  input  1  burst request, sampled on a clock edge while idle.
- cnt  input  CW  burst length in shifts, sampled with start.
- q  output  WIDTH  register contents (registered).
- sout  output  1  combinational equal to q[0] (LSB-first serial out).
- busy  output  1  high while a burst is in progress (registered).
- done  output  1  one-cycle pulse marking burst completion (registered).

## Operation
- FSM has two states, IDLE and SHIFT. Reset state is IDLE.
- IDLE, start=1: latch rem = min(cnt, WIDTH).
  - If rem > 0: go to SHIFT and set busy=1. q is unchanged on this edge.
  - If rem = 0: stay in IDLE, set done=1 for one cycle, q unchanged.
- IDLE, start=0, en=1: perform the mode operation on the edge:
  - 000 hold.
  - 001 load: q <= d.
  - 010 shl: q <= {q[WIDTH-2:0], sin}.
  - 011 shr: q <= {sin, q[WIDTH-1:1]}.
  - 100 rotl: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotr: q <= {q[0], q[WIDTH-1:1]}.
  - 110 clear: q <= 0.
  - 111 invert: q <= ~q.
- IDLE, start=0, en=0: hold.
- start and en both high in IDLE: start wins and the mode operation is discarded.
- SHIFT: on each edge, q <= {sin, q[WIDTH-1:1]} and rem decrements.
  - On the edge where rem goes from 1 to 0: return to IDLE, busy=0, done=1.
- While in SHIFT, en, mode, d, start and cnt are ignored; a start during a burst is dropped, not queued.
- done is high for exactly one cycle and is cleared on the following edge unless a new zero-length burst re-asserts it.
- rem counter width is CW; cnt values above WIDTH saturate to WIDTH.

## Timing
- Reset (rst low, asynchronous): q=RST_VAL, busy=0, done=0, state=IDLE, rem=0. Takes effect immediately without a clock edge.
- Release of rst is synchronous in effect: first active edge is the first edge with rst high.
- Mode operations: one-cycle latency; the result is visible on q after the sampling edge.
- Burst of n>0 sampled at edge k:
  - busy high from edge k to edge k+n.
  - Shifts occur at edges k+1 through k+n.
  - done high in the cycle after edge k+n.
  - A new start is accepted at edge k+n+1 (back-to-back bursts allowed).
- Zero-length burst: done high in the cycle after the sampling edge; busy never rises.
- Reset asserted mid-burst: the burst aborts immediately, q=RST_VAL, and no done pulse is produced.
- sout follows q[0] combinationally; it shows the bit about to be shifted out.

## Test plan
- Reset: WIDTH=8, RST_VAL=8'hA5, rst low at an arbitrary time mid-cycle -> q=8'hA5, busy=0, done=0 with no clock edge required.
- Modes: load d=8'h96, then apply shl (sin=1) -> 8'h2D, rotr -> 8'h96, invert -> 8'h69, clear -> 8'h00. Also apply en=0 with mode=001 -> q holds.
- Burst: q=8'hC3, start with cnt=3, sin=0 ->
  - sout sequence is 1,1,0 on successive cycles.
  - q=8'h18 after the third shift edge.
  - busy high for 3 cycles; done pulses exactly once.
- Boundary counts:
  - cnt=0 -> done in the next cycle, busy stays 0, q unchanged.
  - cnt=15 with WIDTH=8 -> exactly 8 shifts.
  - With sin=1 -> q=8'hFF.
- Collisions:
  - start and en=1, mode=001 in the same cycle -> burst runs and the load is ignored.
  - start pulsed mid-burst -> ignored; only one done pulse.
  - Back-to-back start on the done cycle -> second burst accepted.
- Abort: rst low two cycles into a cnt=5 burst -> q=RST_VAL, busy=0, and no done pulse before or after reset release.
